// File: rtl/gearbox_pkg.sv
// rtl/gearbox_pkg.sv - shared state type for the 2->1 narrowing gearbox
//
// Contents:
//   G21_IDLE/G21_HI/G21_LO  raw 2-bit state encodings
//   g21_state_t             state enum built from those encodings
// No width-dependent types live here; widths belong to the interface/top.
package gearbox_pkg;

  localparam logic [1:0] G21_IDLE = 2'd0;
  localparam logic [1:0] G21_HI   = 2'd1;
  localparam logic [1:0] G21_LO   = 2'd2;

  // IDLE: nothing pending; HI: first half on the output; LO: second half on the output.
  typedef enum logic [1:0] {
    IDLE = G21_IDLE,
    HI   = G21_HI,
    LO   = G21_LO
  } g21_state_t;

endpackage

// File: rtl/gearbox_2_to_1_if.sv
// rtl/gearbox_2_to_1_if.sv - upstream/downstream handshake bundle for gearbox_2_to_1
//
// Parameter:
//   width      downstream half width; upstream word is 2*width
// Signals:
//   up_vld     upstream word valid
//   up_rdy     gearbox can accept up_data this cycle
//   up_data    upstream 2*width word
//   down_vld   down_data holds a valid half
//   down_rdy   downstream accepts the half this cycle
//   down_data  current width-wide half
// Modports:
//   slave      gearbox view (consumes up_*, produces down_*)
//   master     environment view (produces up_*, consumes down_*)
interface gearbox_2_to_1_if #(
  parameter int width = 8
);

  logic               up_vld;
  logic               up_rdy;
  logic [2*width-1:0] up_data;
  logic               down_vld;
  logic               down_rdy;
  logic [width-1:0]   down_data;

  modport slave (
    input  up_vld,
    input  up_data,
    input  down_rdy,
    output up_rdy,
    output down_vld,
    output down_data
  );

  modport master (
    output up_vld,
    output up_data,
    output down_rdy,
    input  up_rdy,
    input  down_vld,
    input  down_data
  );

endinterface

// File: rtl/gearbox_2_to_1.sv
// rtl/gearbox_2_to_1.sv - narrowing gearbox: one 2*width word in, two width halves out
//
// Ports:
//   clk   clock, all state on posedge
//   rst   asynchronous active-low reset
//   bus   gearbox_2_to_1_if.slave (up_vld/up_rdy/up_data, down_vld/down_rdy/down_data)
// Parameter:
//   width downstream half width (must match the interface instance)
// Configuration macro:
//   GEARBOX_2_TO_1_LSB_FIRST_EN  defined: low half emitted first;
//                                undefined: high half emitted first.
module gearbox_2_to_1
  import gearbox_pkg::*;
#(
  parameter int width = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  gearbox_2_to_1_if.slave       bus
);

  g21_state_t         state;
  logic [2*width-1:0] hold;
  logic [width-1:0]   first_half;
  logic [width-1:0]   second_half;

`ifdef GEARBOX_2_TO_1_LSB_FIRST_EN
  assign first_half  = hold[width-1:0];
  assign second_half = hold[2*width-1:width];
`else
  // High half first keeps the {older,newer} packing of the widening gearbox in order.
  assign first_half  = hold[2*width-1:width];
  assign second_half = hold[width-1:0];
`endif

  assign bus.down_vld  = (state != IDLE);
  assign bus.down_data = (state == HI) ? first_half : second_half;

  // Accepting in LO while the last half leaves gives back-to-back words with no bubble.
  // Depends only on state and down_rdy, never on up_vld.
  assign bus.up_rdy = (state == IDLE) || ((state == LO) && bus.down_rdy);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      hold  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.up_vld) begin
            hold  <= bus.up_data;
            state <= HI;
          end
        end
        HI: begin
          if (bus.down_rdy) begin
            state <= LO;
          end
        end
        LO: begin
          if (bus.down_rdy) begin
            if (bus.up_vld) begin
              hold  <= bus.up_data;
              state <= HI;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
